// File: rtl/huff_dec_pkg.sv
// Shared types and constants for the Huffman bitstream decoder.
package huff_dec_pkg;

  localparam int CHAR_W       = 4;
  localparam int LEN_W        = 3;
  localparam int CODE_MAX_DEF = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DECODE = 2'd2
  } state_e;

endpackage

// File: rtl/huff_match.sv
// Combinational table lookup: compares the candidate codeword against every
// table entry and returns the lowest-index entry whose length and code agree.
module huff_match
  import huff_dec_pkg::*;
#(
  parameter int IP_WIDTH = 8,
  parameter int CODE_MAX = CODE_MAX_DEF
) (
  input  logic [IP_WIDTH-1:0][CHAR_W-1:0]   tbl_char,
  input  logic [IP_WIDTH-1:0][CODE_MAX-1:0] tbl_code,
  input  logic [IP_WIDTH-1:0][LEN_W-1:0]    tbl_len,
  input  logic [CODE_MAX-1:0]               acc,
  input  logic [LEN_W-1:0]                  n,
  output logic                              hit,
  output logic [CHAR_W-1:0]                 match_char
);

  logic [CODE_MAX-1:0] mask;

  // Keep only the n low-order bits of acc; higher bits are stale history.
  always_comb begin
    mask = '0;
    for (int b = 0; b < CODE_MAX; b++) begin
      mask[b] = (b < int'(n));
    end
  end

  // Scan from the top down so the lowest matching index is the one left standing.
  // A zero length marks an unused entry and can never match.
  always_comb begin
    hit        = 1'b0;
    match_char = '0;
    for (int k = IP_WIDTH - 1; k >= 0; k--) begin
      if ((tbl_len[k] != '0) && (tbl_len[k] == n) &&
          (((tbl_code[k] ^ acc) & mask) == '0)) begin
        hit        = 1'b1;
        match_char = tbl_char[k];
      end
    end
  end

endmodule

// File: rtl/huff_dec.sv
// Sequential Huffman decoder: loads an IP_WIDTH-entry code table, then decodes
// a serial MSB-first bitstream one bit per cycle.
//
// Handshake: in_valid and bit_valid are plain strobes with no ready; a strobe
// is consumed on the clock edge where it is high and the FSM is in the state
// that uses it (in_valid in IDLE/LOAD, bit_valid in DECODE), otherwise it is
// dropped. bit_last only has meaning together with bit_valid. All outputs are
// registered single-cycle pulses one cycle after the accepting edge.
module huff_dec
  import huff_dec_pkg::*;
#(
  parameter int IP_WIDTH = 8,
  parameter int CODE_MAX = CODE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [CHAR_W-1:0]   in_char,
  input  logic [CODE_MAX-1:0] in_code,
  input  logic [LEN_W-1:0]    in_len,
  input  logic                bit_valid,
  input  logic                bit_in,
  input  logic                bit_last,
  output logic                out_valid,
  output logic [CHAR_W-1:0]   out_char,
  output logic                out_err,
  output logic                out_done
);

  localparam int EW = $clog2(IP_WIDTH);
  localparam int NW = $clog2(CODE_MAX + 1);

  state_e                            state_q, state_d;
  logic [EW-1:0]                     cnt_q, cnt_d;
  logic [CODE_MAX-1:0]               acc_q, acc_d;
  logic [NW-1:0]                     n_q, n_d;
  logic [IP_WIDTH-1:0][CHAR_W-1:0]   tbl_char_q, tbl_char_d;
  logic [IP_WIDTH-1:0][CODE_MAX-1:0] tbl_code_q, tbl_code_d;
  logic [IP_WIDTH-1:0][LEN_W-1:0]    tbl_len_q, tbl_len_d;
  logic                              out_valid_q, out_valid_d;
  logic                              out_err_q, out_err_d;
  logic                              out_done_q, out_done_d;
  logic [CHAR_W-1:0]                 out_char_q, out_char_d;

  logic [CODE_MAX-1:0] acc_nx;
  logic [LEN_W-1:0]    n_nx;
  logic                hit;
  logic [CHAR_W-1:0]   hit_char;

  // Candidate codeword if the current stream bit is accepted.
  assign acc_nx = {acc_q[CODE_MAX-2:0], bit_in};
  assign n_nx   = LEN_W'(n_q) + LEN_W'(1);

  huff_match #(
    .IP_WIDTH (IP_WIDTH),
    .CODE_MAX (CODE_MAX)
  ) u_match (
    .tbl_char   (tbl_char_q),
    .tbl_code   (tbl_code_q),
    .tbl_len    (tbl_len_q),
    .acc        (acc_nx),
    .n          (n_nx),
    .hit        (hit),
    .match_char (hit_char)
  );

  // Next-state, table write and decode-outcome logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    n_d         = n_q;
    tbl_char_d  = tbl_char_q;
    tbl_code_d  = tbl_code_q;
    tbl_len_d   = tbl_len_q;
    out_valid_d = 1'b0;
    out_err_d   = 1'b0;
    out_done_d  = 1'b0;
    out_char_d  = out_char_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          tbl_char_d[0] = in_char;
          tbl_code_d[0] = in_code;
          tbl_len_d[0]  = in_len;
          cnt_d         = EW'(1);
          state_d       = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          tbl_char_d[cnt_q] = in_char;
          tbl_code_d[cnt_q] = in_code;
          tbl_len_d[cnt_q]  = in_len;
          if (cnt_q == EW'(IP_WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = DECODE;
          end else begin
            cnt_d = cnt_q + EW'(1);
          end
        end
      end
      DECODE: begin
        if (bit_valid) begin
          acc_d = acc_nx;
          n_d   = NW'(n_nx);
          if (hit) begin
            out_valid_d = 1'b1;
            out_char_d  = hit_char;
            acc_d       = '0;
            n_d         = '0;
          end else if ((n_nx == LEN_W'(CODE_MAX)) || bit_last) begin
            // Longest legal code exhausted, or stream ended mid-codeword.
            out_err_d = 1'b1;
            acc_d     = '0;
            n_d       = '0;
          end
          if (bit_last) begin
            out_done_d = 1'b1;
            acc_d      = '0;
            n_d        = '0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      n_q         <= '0;
      tbl_char_q  <= '0;
      tbl_code_q  <= '0;
      tbl_len_q   <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_done_q  <= 1'b0;
      out_char_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      n_q         <= n_d;
      tbl_char_q  <= tbl_char_d;
      tbl_code_q  <= tbl_code_d;
      tbl_len_q   <= tbl_len_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_done_q  <= out_done_d;
      out_char_q  <= out_char_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign out_err   = out_err_q;
  assign out_done  = out_done_q;

endmodule

// File: tb/tb_huff_dec.sv
// Directed bench for huff_dec: table loads, legal/illegal/truncated streams,
// resets mid-load and mid-decode, gapped strobes and one-char-per-cycle output.
module tb_huff_dec;
  import huff_dec_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_char;
  logic [6:0] in_code;
  logic [2:0] in_len;
  logic       bit_valid;
  logic       bit_in;
  logic       bit_last;
  logic       out_valid;
  logic [3:0] out_char;
  logic       out_err;
  logic       out_done;

  int n_cmp = 0;
  int n_mis = 0;
  int extra_pulses = 0;

  // Table image driven by load_table.
  logic [3:0] tc[8];
  logic [6:0] tcode[8];
  logic [2:0] tl[8];

  // Per-bit observations captured by send_stream.
  logic [15:0] o_v, o_e, o_d;
  logic [3:0]  o_c[16];

  huff_dec #(.IP_WIDTH(8), .CODE_MAX(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_code   (in_code),
    .in_len    (in_len),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .bit_last  (bit_last),
    .out_valid (out_valid),
    .out_char  (out_char),
    .out_err   (out_err),
    .out_done  (out_done)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Driver: A..H = chars 1..8 with a full unary-style Huffman tree.
  task automatic set_default_table();
    for (int k = 0; k < 8; k++) begin
      tc[k] = 4'(k + 1);
      tl[k] = (k == 7) ? 3'd7 : 3'(k + 1);
    end
    tcode[0] = 7'b0000000; tcode[1] = 7'b0000010; tcode[2] = 7'b0000110;
    tcode[3] = 7'b0001110; tcode[4] = 7'b0011110; tcode[5] = 7'b0111110;
    tcode[6] = 7'b1111110; tcode[7] = 7'b1111111;
  endtask

  // Driver: load n_ent entries; with noise, an in_valid gap carrying a stray
  // bit_valid/bit_last precedes each entry and stray bits ride on the entry cycles.
  task automatic load_table(input int n_ent, input logic noise);
    for (int k = 0; k < n_ent; k++) begin
      if (noise) begin
        bit_valid = 1'b1; bit_in = 1'b1; bit_last = 1'b1;
        @(negedge clk);
        if (out_valid || out_err || out_done) extra_pulses++;
      end
      in_valid = 1'b1; in_char = tc[k]; in_code = tcode[k]; in_len = tl[k];
      bit_valid = noise; bit_in = 1'b0; bit_last = noise;
      @(negedge clk);
      if (out_valid || out_err || out_done) extra_pulses++;
      in_valid = 1'b0; bit_valid = 1'b0; bit_last = 1'b0; bit_in = 1'b0;
    end
  endtask

  // Driver: send nb bits, bits[nb-1] first, with gap idle cycles before each bit.
  task automatic send_stream(input logic [15:0] bits, input int nb, input int gap,
                             input logic with_last);
    o_v = '0; o_e = '0; o_d = '0;
    for (int i = 0; i < nb; i++) begin
      for (int g = 0; g < gap; g++) begin
        bit_valid = 1'b0;
        @(negedge clk);
        if (out_valid || out_err || out_done) extra_pulses++;
      end
      bit_valid = 1'b1;
      bit_in    = bits[nb-1-i];
      bit_last  = with_last && (i == nb - 1);
      @(negedge clk);
      bit_valid = 1'b0; bit_last = 1'b0; bit_in = 1'b0;
      o_v[i] = out_valid; o_e[i] = out_err; o_d[i] = out_done; o_c[i] = out_char;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_err !== 1'b0) begin n_mis++; $display("FAIL reset_err: got %b want 0", out_err); end
    n_cmp++; if (out_done !== 1'b0) begin n_mis++; $display("FAIL reset_done: got %b want 0", out_done); end
    n_cmp++; if (out_char !== 4'd0) begin n_mis++; $display("FAIL reset_char: got %0d want 0", out_char); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_mis++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
    rst_n = 1'b1;
    @(negedge clk);
    // No table loaded: bits must be ignored in IDLE.
    send_stream(16'b0, 1, 0, 1'b1);
    n_cmp++; if ({o_v[0], o_e[0], o_d[0]} !== 3'b000) begin n_mis++; $display("FAIL idle_bits_ignored: got v/e/d=%b%b%b want 000", o_v[0], o_e[0], o_d[0]); end
  endtask

  task automatic test_basic();
    logic [15:0] ev, ed;
    logic [3:0]  ec[16];
    ev = 16'b100101; ed = 16'b100000;
    ec[0] = 4'd1; ec[2] = 4'd2; ec[5] = 4'd3;
    set_default_table();
    load_table(8, 1'b0);
    send_stream(16'b010110, 6, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if ({o_v[i], o_e[i], o_d[i]} !== {ev[i], 1'b0, ed[i]}) begin
        n_mis++; $display("FAIL basic_flags bit%0d: got v/e/d=%b%b%b want %b0%b", i, o_v[i], o_e[i], o_d[i], ev[i], ed[i]);
      end
      if (ev[i]) begin
        n_cmp++; if (o_c[i] !== ec[i]) begin n_mis++; $display("FAIL basic_char bit%0d: got %0d want %0d", i, o_c[i], ec[i]); end
      end
    end
    n_cmp++; if (dut.state_q !== IDLE) begin n_mis++; $display("FAIL basic_state: got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_long_code();
    set_default_table();
    load_table(8, 1'b0);
    send_stream(16'b1111111, 7, 0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if ({o_v[i], o_e[i], o_d[i]} !== ((i == 6) ? 3'b101 : 3'b000)) begin
        n_mis++; $display("FAIL long_flags bit%0d: got v/e/d=%b%b%b want %s", i, o_v[i], o_e[i], o_d[i], (i == 6) ? "101" : "000");
      end
    end
    n_cmp++; if (o_c[6] !== 4'd8) begin n_mis++; $display("FAIL long_char: got %0d want 8", o_c[6]); end
  endtask

  task automatic test_illegal();
    set_default_table();
    tl[7] = 3'd0;
    load_table(8, 1'b0);
    send_stream(16'b1111111, 7, 0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if ({o_v[i], o_e[i], o_d[i]} !== ((i == 6) ? 3'b010 : 3'b000)) begin
        n_mis++; $display("FAIL illegal_flags bit%0d: got v/e/d=%b%b%b want %s", i, o_v[i], o_e[i], o_d[i], (i == 6) ? "010" : "000");
      end
    end
    send_stream(16'b0, 1, 0, 1'b1);
    n_cmp++; if ({o_v[0], o_e[0], o_d[0]} !== 3'b101) begin n_mis++; $display("FAIL illegal_resume_flags: got v/e/d=%b%b%b want 101", o_v[0], o_e[0], o_d[0]); end
    n_cmp++; if (o_c[0] !== 4'd1) begin n_mis++; $display("FAIL illegal_resume_char: got %0d want 1", o_c[0]); end
  endtask

  task automatic test_truncated();
    set_default_table();
    load_table(8, 1'b0);
    send_stream(16'b11, 2, 0, 1'b1);
    n_cmp++; if ({o_v[0], o_e[0], o_d[0]} !== 3'b000) begin n_mis++; $display("FAIL trunc_bit0: got v/e/d=%b%b%b want 000", o_v[0], o_e[0], o_d[0]); end
    n_cmp++; if ({o_v[1], o_e[1], o_d[1]} !== 3'b011) begin n_mis++; $display("FAIL trunc_bit1: got v/e/d=%b%b%b want 011", o_v[1], o_e[1], o_d[1]); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_mis++; $display("FAIL trunc_state: got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_reset_mid_load();
    set_default_table();
    tcode[0] = 7'b0000010; tl[0] = 3'd2;  // A = "10"
    tcode[1] = 7'b0000000; tl[1] = 3'd1;  // B = "0"
    load_table(3, 1'b0);
    do_reset();
    @(negedge clk);
    n_cmp++; if (dut.state_q !== IDLE) begin n_mis++; $display("FAIL midload_state: got %0d want IDLE", dut.state_q); end
    n_cmp++; if ({out_valid, out_err, out_done} !== 3'b000) begin n_mis++; $display("FAIL midload_outs: got v/e/d=%b%b%b want 000", out_valid, out_err, out_done); end
    load_table(8, 1'b0);
    send_stream(16'b0, 1, 0, 1'b1);
    n_cmp++; if ({o_v[0], o_e[0], o_d[0]} !== 3'b101) begin n_mis++; $display("FAIL midload_flags: got v/e/d=%b%b%b want 101", o_v[0], o_e[0], o_d[0]); end
    n_cmp++; if (o_c[0] !== 4'd2) begin n_mis++; $display("FAIL midload_char: got %0d want 2", o_c[0]); end
  endtask

  task automatic test_reset_mid_decode();
    set_default_table();
    load_table(8, 1'b0);
    send_stream(16'b11, 2, 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_err !== 1'b0) begin n_mis++; $display("FAIL middec_err: got %b want 0", out_err); end
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (dut.state_q !== IDLE) begin n_mis++; $display("FAIL middec_state: got %0d want IDLE", dut.state_q); end
    load_table(8, 1'b0);
    send_stream(16'b0, 1, 0, 1'b1);
    n_cmp++; if ({o_v[0], o_e[0], o_d[0]} !== 3'b101) begin n_mis++; $display("FAIL middec_flags: got v/e/d=%b%b%b want 101", o_v[0], o_e[0], o_d[0]); end
    n_cmp++; if (o_c[0] !== 4'd1) begin n_mis++; $display("FAIL middec_char: got %0d want 1", o_c[0]); end
  endtask

  task automatic test_gaps();
    logic [15:0] ev, ed;
    logic [3:0]  ec[16];
    ev = 16'b100101; ed = 16'b100000;
    ec[0] = 4'd1; ec[2] = 4'd2; ec[5] = 4'd3;
    extra_pulses = 0;
    set_default_table();
    load_table(8, 1'b1);
    send_stream(16'b010110, 6, 2, 1'b1);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if ({o_v[i], o_e[i], o_d[i]} !== {ev[i], 1'b0, ed[i]}) begin
        n_mis++; $display("FAIL gaps_flags bit%0d: got v/e/d=%b%b%b want %b0%b", i, o_v[i], o_e[i], o_d[i], ev[i], ed[i]);
      end
      if (ev[i]) begin
        n_cmp++; if (o_c[i] !== ec[i]) begin n_mis++; $display("FAIL gaps_char bit%0d: got %0d want %0d", i, o_c[i], ec[i]); end
      end
    end
    n_cmp++; if (extra_pulses !== 0) begin n_mis++; $display("FAIL gaps_stray_pulses: got %0d want 0", extra_pulses); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ec[16];
    ec[0] = 4'd2; ec[1] = 4'd1; ec[2] = 4'd2; ec[3] = 4'd2; ec[4] = 4'd1;
    for (int k = 0; k < 8; k++) begin
      tc[k] = 4'd15; tcode[k] = 7'b0; tl[k] = 3'd0;
    end
    tc[0] = 4'd1; tcode[0] = 7'b0000000; tl[0] = 3'd1;
    tc[1] = 4'd2; tcode[1] = 7'b0000001; tl[1] = 3'd1;
    tc[2] = 4'd9; tcode[2] = 7'b0000001; tl[2] = 3'd1;  // shadowed by entry 1
    load_table(8, 1'b0);
    send_stream(16'b10110, 5, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({o_v[i], o_e[i], o_d[i]} !== {1'b1, 1'b0, (i == 4)}) begin
        n_mis++; $display("FAIL b2b_flags bit%0d: got v/e/d=%b%b%b want 10%b", i, o_v[i], o_e[i], o_d[i], (i == 4));
      end
      n_cmp++; if (o_c[i] !== ec[i]) begin n_mis++; $display("FAIL b2b_char bit%0d: got %0d want %0d", i, o_c[i], ec[i]); end
    end
  endtask

  // Test sequence and final report.
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_char = '0; in_code = '0; in_len = '0;
    bit_valid = 1'b0; bit_in = 1'b0; bit_last = 1'b0;
    test_reset();
    test_basic();
    test_long_code();
    test_illegal();
    test_truncated();
    test_reset_mid_load();
    test_reset_mid_decode();
    test_gaps();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
